// File: rtl/axi_txn_limiter.sv
// AXI outstanding-transaction limiter with flush/drain; AXI_TXN_LIMITER_ATOP_EN counts atomics as reads too.
// Latency: zero cycles on every channel; only AR/AW valid/ready are gated, everything else is wired through.
// Backpressure: a new AR/AW is held (ready=0) at its outstanding limit or while draining; an offered one is never withdrawn.

package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_txn_limiter #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned MaxReads  = 8,
    parameter int unsigned MaxWrites = 8,
    parameter type req_t  = ariane_axi::req_t,
    parameter type resp_t = ariane_axi::resp_t,
    localparam int unsigned RdCntW = $clog2(MaxReads + 1),
    localparam int unsigned WrCntW = $clog2(MaxWrites + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  req_t              slv_req_i,
    output resp_t             slv_resp_o,
    output req_t              mst_req_o,
    input  resp_t             mst_resp_i,
    input  logic              flush_i,
    output logic              drained_o,
    output logic [RdCntW-1:0] rd_cnt_o,
    output logic [WrCntW-1:0] wr_cnt_o
);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_e;

    state_e            state_q;
    logic              drained_q;
    logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
    logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
    logic              ar_presented_q, ar_presented_d;
    logic              aw_presented_q, aw_presented_d;
    logic              ar_open, aw_open, ar_fwd, aw_fwd;
    logic              ar_hs, aw_hs, r_last_hs, b_hs;
    logic              rd_inc_atop;
    logic              idle_next;

`ifdef AXI_TXN_LIMITER_ATOP_EN
    logic aw_atop;
    assign aw_atop = slv_req_i.aw.atop[5];
    assign aw_open = (state_q == RUN) && (wr_cnt_q < WrCntW'(MaxWrites))
                  && (!aw_atop || (int'(rd_cnt_q) + int'(ar_presented_q) < int'(MaxReads)));
    assign aw_fwd  = aw_presented_q || aw_open;
    // An atomic AW on offer downstream reserves a read slot so a new AR cannot overrun rd_cnt.
    assign ar_open = (state_q == RUN)
                  && (int'(rd_cnt_q) + int'(aw_fwd && slv_req_i.aw_valid && aw_atop) < int'(MaxReads));
    assign rd_inc_atop = aw_hs && aw_atop;
`else
    assign aw_open = (state_q == RUN) && (wr_cnt_q < WrCntW'(MaxWrites));
    assign aw_fwd  = aw_presented_q || aw_open;
    assign ar_open = (state_q == RUN) && (rd_cnt_q < RdCntW'(MaxReads));
    assign rd_inc_atop = 1'b0;
`endif

    assign ar_fwd = ar_presented_q || ar_open;

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_fwd;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_fwd;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_fwd;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_fwd;
    end

    assign ar_hs     = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign aw_hs     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;

    assign rd_cnt_d = rd_cnt_q + RdCntW'(ar_hs) + RdCntW'(rd_inc_atop) - RdCntW'(r_last_hs);
    assign wr_cnt_d = wr_cnt_q + WrCntW'(aw_hs) - WrCntW'(b_hs);
    assign ar_presented_d = mst_req_o.ar_valid && !mst_resp_i.ar_ready;
    assign aw_presented_d = mst_req_o.aw_valid && !mst_resp_i.aw_ready;

    // Next-cycle values so drained_o rises the cycle right after the final response.
    assign idle_next = (rd_cnt_d == '0) && (wr_cnt_d == '0) && !ar_presented_d && !aw_presented_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= RUN;
            drained_q      <= 1'b0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            ar_presented_q <= 1'b0;
            aw_presented_q <= 1'b0;
        end else begin
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            ar_presented_q <= ar_presented_d;
            aw_presented_q <= aw_presented_d;
            unique case (state_q)
                RUN: begin
                    if (flush_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!flush_i) begin
                        state_q <= RUN;
                    end else if (idle_next) begin
                        state_q   <= DRAINED;
                        drained_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!flush_i) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    assign drained_o = drained_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;

    logic cfg_ok;
    assign cfg_ok = ($bits(slv_req_i.aw.addr) == AddrWidth) && ($bits(slv_req_i.w.data) == DataWidth)
                 && ($bits(slv_req_i.aw.id) == IdWidth) && ($bits(slv_req_i.aw.user) == UserWidth)
                 && (MaxReads >= 1) && (MaxWrites >= 1);

    cfg_check: assert property (@(posedge clk_i) cfg_ok);
    rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && rd_cnt_q == '0));
    wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && wr_cnt_q == '0));

endmodule

// File: doc/axi_txn_limiter.md
AXI_TXN_LIMITER -- requirements
Module: axi_txn_limiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AddrWidth, 64: AXI address width.
- DataWidth, 64: AXI data width.
- IdWidth, 4: AXI ID width.
- UserWidth, 1: AXI user width.
- MaxReads, 8: outstanding read limit, at least 1.
- MaxWrites, 8: outstanding write limit, at least 1.
- req_t, ariane_axi::req_t: AXI request struct type.
- resp_t, ariane_axi::resp_t: AXI response struct type.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- slv_req_i, in, req_t: request from upstream.
- slv_resp_o, out, resp_t: response to upstream.
- mst_req_o, out, req_t: request to downstream.
- mst_resp_i, in, resp_t: response from downstream.
- flush_i, in, 1: stop issuing new AR/AW and drain.
- drained_o, out, 1: flush active and nothing outstanding.
- rd_cnt_o, out, $clog2(MaxReads+1): outstanding read count.
- wr_cnt_o, out, $clog2(MaxWrites+1): outstanding write count.

Function
REQ-003 The W, B and R channels, and all payload fields, SHALL pass combinationally between slave and master sides without alteration.
REQ-004 rd_cnt SHALL increment on each AR handshake at the master side and decrement on each R handshake with r.last=1; when both occur in the same cycle it SHALL stay unchanged.
REQ-005 wr_cnt SHALL increment on each AW handshake at the master side and decrement on each B handshake; when both occur in the same cycle it SHALL stay unchanged.
REQ-006 A new AR SHALL be forwarded (mst ar_valid=slv ar_valid, slv ar_ready=mst ar_ready) only when rd_cnt<MaxReads and the FSM is RUN; otherwise mst ar_valid=0 and slv ar_ready=0.
REQ-007 AW SHALL follow the same rule as AR, using wr_cnt<MaxWrites.
REQ-008 The block SHALL register whether mst ar_valid was asserted without ar_ready (ar_presented_q); while it is set, AR SHALL stay forwarded regardless of count or flush, so that a valid is never withdrawn before its handshake. aw_presented_q SHALL apply the same rule to AW.
REQ-009 The FSM SHALL have three states:
- RUN to DRAIN when flush_i=1.
- DRAIN to DRAINED when rd_cnt=0, wr_cnt=0 and neither presented flag is set.
- DRAIN or DRAINED to RUN when flush_i=0.
REQ-010 drained_o SHALL be 1 only in DRAINED; new AR/AW SHALL be blocked in both DRAIN and DRAINED.
REQ-011 Counters SHALL neither wrap nor underflow; a decrement at 0 is a protocol error and SHALL be flagged by an assertion, not by logic.
REQ-012 Added latency on all channels SHALL be zero cycles.

Reset
REQ-013 While rst_ni=0 (asynchronous), the block SHALL force rd_cnt=0, wr_cnt=0, both presented flags=0, FSM=RUN and drained_o=0.
REQ-014 A reset asserted mid-transaction SHALL discard all outstanding state, with no recovery of in-flight transactions.

Configuration
REQ-015 With macro AXI_TXN_LIMITER_ATOP_EN defined, an AW with atop[5]=1 SHALL require both wr_cnt<MaxWrites and rd_cnt<MaxReads, and its handshake SHALL increment both counters; the matching R last SHALL decrement rd_cnt.
REQ-016 Without AXI_TXN_LIMITER_ATOP_EN, every AW SHALL be counted as a write only, and atop SHALL have no effect on the counters.

Verification
REQ-017 MaxReads=2; issue 3 ARs with no R -> the first two handshake, the third is held with slv ar_ready=0 and rd_cnt=2; one R last -> the third handshakes in the following cycle.
REQ-018 rd_cnt=1; AR handshake and R last in the same cycle -> rd_cnt stays 1.
REQ-019 mst ar_valid=1, ar_ready=0, then flush_i=1 -> AR remains valid until handshake, then drains; after the last R, drained_o=1 in the next cycle.
REQ-020 flush_i pulsed high for 3 cycles with counts 0 -> DRAINED entered, then RUN on deassertion; new AW accepted.
REQ-021 ATOP_EN defined, MaxReads=1, rd_cnt=1, AW with atop=6'b100000 -> AW blocked; without the macro -> AW accepted and rd_cnt stays 1.
REQ-022 rst_ni pulsed low with rd_cnt=3 and wr_cnt=2 -> both counters read 0 immediately, without waiting for a clock edge.
